// File: rtl/uncached_write_buffer_pkg.sv
// Shared types for the uncached store buffer: the buffered entry layout,
// the default depth and the drain FSM state encoding.
package uncached_write_buffer_pkg;

    localparam int unsigned UWB_DEPTH = 4;

    typedef struct packed {
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } uwb_entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } uwb_state_e;

endpackage

// File: rtl/uwb_fifo.sv
// Entry storage for the uncached write buffer: circular array, read/write
// pointers and occupancy count. Head entry is read combinationally.
module uwb_fifo
    import uncached_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = UWB_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  uwb_entry_t               i_wentry,
    input  logic                     i_pop,
    output uwb_entry_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    uwb_entry_t          r_mem [DEPTH];
    logic [PtrW-1:0]     r_wptr;
    logic [PtrW-1:0]     r_rptr;
    logic [PtrW:0]       r_count;

    // Storage is intentionally not reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wentry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/uncached_write_buffer.sv
// Posted buffer for uncached stores: stores complete to the memory stage one
// cycle after acceptance and are drained to the uncached bus in order.
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = UWB_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    output logic        empty,
    output logic        full
);

    localparam int unsigned   PtrW    = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

    uwb_state_e     r_state;
    logic           r_bus_req;
    logic           r_data_ok;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic [PtrW:0]  w_count;
    logic [PtrW:0]  w_count_next;
    uwb_entry_t     w_wentry;
    uwb_entry_t     w_head;

    // Full looks only at the registered count, so a same-cycle pop never frees a slot.
    assign w_full      = (w_count == FullCnt);
    assign cpu_addr_ok = cpu_req && cpu_wr && !w_full;
    assign w_push      = cpu_req && cpu_addr_ok;
    assign w_pop       = (r_state == StWait) && bus_data_ok;
    assign w_count_next = w_count + {{PtrW{1'b0}}, w_push} - {{PtrW{1'b0}}, w_pop};

    assign w_wentry = '{size: cpu_size, wstrb: cpu_wstrb, addr: cpu_addr, wdata: cpu_wdata};

    uwb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .i_push   (w_push),
        .i_wentry (w_wentry),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count)
    );

    // Looking at the post-update count lets a store accepted in IDLE reach the bus next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= StIdle;
            r_bus_req <= 1'b0;
            r_data_ok <= 1'b0;
        end else begin
            r_data_ok <= w_push;
            unique case (r_state)
                StIdle: begin
                    if (w_count_next != '0) begin
                        r_state   <= StReq;
                        r_bus_req <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus_addr_ok) begin
                        r_state   <= StWait;
                        r_bus_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus_data_ok) begin
                        if (w_count_next != '0) begin
                            r_state   <= StReq;
                            r_bus_req <= 1'b1;
                        end else begin
                            r_state   <= StIdle;
                            r_bus_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_data_ok = r_data_ok;
    assign bus_req     = r_bus_req;
    assign bus_wr      = 1'b1;
    assign bus_size    = w_head.size;
    assign bus_wstrb   = w_head.wstrb;
    assign bus_addr    = w_head.addr;
    assign bus_wdata   = w_head.wdata;
    assign empty       = (w_count == '0) && (r_state == StIdle);
    assign full        = w_full;

endmodule

// File: tb/tb_uncached_write_buffer.sv
// Bench for uncached_write_buffer: directed scenarios plus random traffic, checked
// against a queue-based model of the buffer contents by a negedge monitor.
module tb_uncached_write_buffer;
    import uncached_write_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic        empty, full;

    uncached_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_size    (cpu_size),
        .cpu_wstrb   (cpu_wstrb),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_addr_ok (cpu_addr_ok),
        .cpu_data_ok (cpu_data_ok),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .empty       (empty),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: stores held by the buffer, oldest first, plus whether the
    // head has been handed to the bus and is awaiting completion.
    uwb_entry_t  mq[$];
    logic [31:0] bus_log[$];
    bit          outstanding = 0;
    bit          exp_dok = 0;
    bit          m_acc, m_was_out, m_exp_req;
    bit          auto_bus = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            mq.delete();
            outstanding = 0;
            exp_dok     = 0;
            chk("rst_bus_req", bus_req, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_data_ok", cpu_data_ok, 0);
        end else begin
            m_exp_req = (mq.size() > 0) && !outstanding;
            m_acc     = cpu_req && cpu_wr && (mq.size() < DEPTH);
            chk("data_ok", cpu_data_ok, exp_dok);
            chk("addr_ok", cpu_addr_ok, m_acc);
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("bus_req", bus_req, m_exp_req);
            if (bus_req && mq.size() > 0) begin
                chk("bus_wr", bus_wr, 1);
                chk("bus_addr", bus_addr, mq[0].addr);
                chk("bus_wdata", bus_wdata, mq[0].wdata);
                chk("bus_wstrb", bus_wstrb, mq[0].wstrb);
                chk("bus_size", bus_size, mq[0].size);
            end
            m_was_out = outstanding;
            if (bus_req && bus_addr_ok) begin
                outstanding = 1;
                bus_log.push_back(bus_addr);
            end
            if (m_was_out && bus_data_ok) begin
                void'(mq.pop_front());
                outstanding = 0;
            end
            if (m_acc) begin
                mq.push_back('{size: cpu_size, wstrb: cpu_wstrb, addr: cpu_addr,
                               wdata: cpu_wdata});
            end
            exp_dok = m_acc;
        end
    end

    // Auto bus slave with random 0-5 cycle gaps before addr_ok and data_ok.
    initial forever begin
        @(negedge clk);
        if (auto_bus && resetn && bus_req) begin
            @(posedge clk); #1;
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            bus_addr_ok = 1'b1;
            @(posedge clk); #1;
            bus_addr_ok = 1'b0;
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            bus_data_ok = 1'b1;
            @(posedge clk); #1;
            bus_data_ok = 1'b0;
        end
    end

    task automatic send_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] sz);
        int  n = 0;
        bit  acc = 0;
        cpu_req = 1'b1; cpu_wr = 1'b1;
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_size = sz;
        do begin
            @(negedge clk);
            acc = cpu_addr_ok;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("store_accept_timeout", 0, 1);
        cpu_req = 1'b0;
    endtask

    task automatic bus_accept();
        int n = 0;
        while (!bus_req && n < 100) begin @(posedge clk); #1; n++; end
        chk("bus_req_wait", bus_req, 1);
        bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
    endtask

    task automatic bus_complete();
        bus_data_ok = 1'b1;
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!empty && n < 1000) begin @(posedge clk); #1; n++; end
        chk("drain_timeout", empty, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_wstrb = 0; cpu_addr = 0; cpu_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Single store
        send_store(32'h1FAF_F000, 32'h1234_5678, 4'hF, 2'd2);
        chk("single_data_ok", cpu_data_ok, 1);
        chk("single_bus_req", bus_req, 1);
        chk("single_bus_addr", bus_addr, 32'h1FAF_F000);
        chk("single_bus_wdata", bus_wdata, 32'h1234_5678);
        chk("single_bus_wstrb", bus_wstrb, 4'hF);
        bus_accept();
        bus_complete();
        chk("single_empty", empty, 1);
        @(posedge clk); #1;

        // Fill to DEPTH with the bus stalled, then a 5th store must wait for a pop
        for (int i = 0; i < DEPTH; i++) send_store(32'h1000_0000 + 4 * i, $urandom, 4'hF, 2'd2);
        chk("fill_full", full, 1);
        fork
            send_store(32'h1000_0100, 32'hCAFE_0005, 4'h3, 2'd1);
            begin
                repeat (3) begin @(negedge clk); chk("fill_blocked", cpu_addr_ok, 0); end
                @(posedge clk); #1;
                bus_accept();
                bus_complete();
            end
        join
        auto_bus = 1;
        wait_empty();
        auto_bus = 0;

        // Load rejection
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h1FAF_0010;
        repeat (3) begin
            @(negedge clk);
            chk("load_addr_ok", cpu_addr_ok, 0);
            chk("load_empty", empty, 1);
        end
        @(posedge clk); #1;
        cpu_req = 0;
        @(posedge clk); #1;
        chk("load_no_bus_req", bus_req, 0);

        // Simultaneous enqueue and pop with two entries held
        send_store(32'h2000_0000, 32'hAAAA_0001, 4'hF, 2'd2);
        send_store(32'h2000_0004, 32'hAAAA_0002, 4'hF, 2'd2);
        bus_accept();
        cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h2000_0008; cpu_wdata = 32'hAAAA_0003;
        cpu_wstrb = 4'hC; cpu_size = 2'd1;
        bus_data_ok = 1;
        @(negedge clk);
        chk("simul_addr_ok", cpu_addr_ok, 1);
        @(posedge clk); #1;
        cpu_req = 0; bus_data_ok = 0;
        chk("simul_full", full, 0);
        chk("simul_empty", empty, 0);
        chk("simul_bus_req", bus_req, 1);
        chk("simul_head", bus_addr, 32'h2000_0004);
        chk("simul_data_ok", cpu_data_ok, 1);
        auto_bus = 1;
        wait_empty();

        // In-order drain with wrap: ten sequential stores under random bus latency
        bus_log.delete();
        for (int i = 0; i < 10; i++) begin
            send_store(32'h1FD0_0000 + 4 * i, $urandom, 4'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_empty();
        chk("order_count", bus_log.size(), 10);
        for (int i = 0; i < 10 && i < bus_log.size(); i++)
            chk("order_addr", bus_log[i], 32'h1FD0_0000 + 4 * i);

        // Random traffic including occasional loads
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cpu_req = 1; cpu_wr = 0; cpu_addr = $urandom;
                @(posedge clk); #1;
                cpu_req = 0;
            end else begin
                send_store($urandom, $urandom, 4'($urandom), 2'($urandom));
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_empty();
        auto_bus = 0;

        // Reset while waiting on the bus with three entries
        for (int i = 0; i < 3; i++) send_store(32'h3000_0000 + 4 * i, $urandom, 4'hF, 2'd2);
        bus_accept();
        resetn = 0;
        #1;
        chk("midrst_bus_req", bus_req, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_full", full, 0);
        chk("midrst_data_ok", cpu_data_ok, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        @(posedge clk); #1;
        bus_complete();
        chk("late_dok_empty", empty, 1);
        chk("late_dok_bus_req", bus_req, 0);
        chk("late_dok_full", full, 0);
        send_store(32'h3000_0100, 32'h5555_AAAA, 4'hF, 2'd2);
        chk("post_rst_head", bus_addr, 32'h3000_0100);
        auto_bus = 1;
        wait_empty();
        auto_bus = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uncached_write_buffer.md
UNCACHED_WRITE_BUFFER -- requirements
Module: uncached_write_buffer

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 4, number of buffered uncached stores (power of two, >=2).
REQ-002 The port list SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request from pre_memory DBus path (uncached).
- cpu_wr  in  1  1=store.
- cpu_size  in  2  access size.
- cpu_wstrb  in  4  byte enables.
- cpu_addr  in  32  physical address.
- cpu_wdata  in  32  store data.
- cpu_addr_ok  out  1  request accepted.
- cpu_data_ok  out  1  store completion to memory stage.
- bus_req  out  1  write request to uncached bus.
- bus_wr  out  1  constant 1.
- bus_size  out  2  head entry size.
- bus_wstrb  out  4  head entry strobes.
- bus_addr  out  32  head entry address.
- bus_wdata  out  32  head entry data.
- bus_addr_ok  in  1  bus accepted request.
- bus_data_ok  in  1  bus write completed.
- empty  out  1  no entries and drain FSM idle; control holds uncached loads until 1.
- full  out  1  count == DEPTH.

Function
REQ-003 The block SHALL buffer uncached stores in a FIFO of DEPTH entries {size, wstrb, addr, wdata}.
REQ-004 cpu_addr_ok SHALL equal cpu_req && cpu_wr && !full (combinational); loads (cpu_wr=0) SHALL never be accepted.
REQ-005 An entry SHALL be enqueued at the tail on the edge where cpu_req && cpu_addr_ok.
REQ-006 cpu_data_ok SHALL be a register set exactly one cycle after each accepted store and cleared otherwise (store latency to memory stage = 1 cycle, independent of bus).
REQ-007 Full SHALL be evaluated on the registered count only; a same-cycle pop SHALL NOT free a slot for a same-cycle enqueue.
REQ-008 The drain FSM SHALL have states IDLE, REQ, WAIT.
REQ-009 IDLE -> REQ when count != 0; REQ -> WAIT on bus_addr_ok; WAIT -> REQ on bus_data_ok when count after pop != 0, else WAIT -> IDLE.
REQ-010 bus_req SHALL be 1 only in REQ; bus_size/wstrb/addr/wdata SHALL present the head entry and stay stable from REQ entry until bus_addr_ok.
REQ-011 The head SHALL be popped on the edge where state==WAIT && bus_data_ok.
REQ-012 bus_data_ok in IDLE or REQ SHALL be ignored.
REQ-013 Simultaneous enqueue and pop SHALL leave count unchanged and advance both pointers.
REQ-014 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-015 empty SHALL be count==0 && state==IDLE; full SHALL be count==DEPTH.
REQ-016 Stores SHALL be issued to the bus strictly in acceptance order, one outstanding at a time.

Reset
REQ-017 On resetn=0, asynchronously: state=IDLE, pointers=0, count=0, cpu_data_ok=0, bus_req=0, empty=1, full=0; entry storage need not be cleared.
REQ-018 Reset mid-drain SHALL discard all entries; a bus_data_ok arriving after reset release SHALL be ignored per REQ-012.

Structure
REQ-019 The typedef uwb_entry_t {size, wstrb, addr, wdata} and constant UWB_DEPTH SHALL live in the shared cpu package header.
REQ-020 Entry storage and pointers SHALL be one sub-module, uwb_fifo; FSM and handshakes SHALL stay in uncached_write_buffer.

Verification
REQ-021 Single store: addr 0x1FAF_F000, data 0x1234_5678, wstrb 4'hF -> addr_ok same cycle, data_ok next cycle, bus_req next cycle with identical fields; empty returns to 1 one cycle after bus_data_ok.
REQ-022 Fill: 4 back-to-back stores, bus_addr_ok held 0 -> full=1 after 4th; 5th cpu_req sees addr_ok=0 until first bus_data_ok pop.
REQ-023 Ordering/wrap: 10 stores addr 0x1FD0_0000+4*i with random bus latencies 0-5 -> bus writes in order i=0..9, pointers wrap twice, no loss or duplication.
REQ-024 Simultaneous: count=2 in WAIT, enqueue and bus_data_ok same cycle -> count stays 2, FSM enters REQ with next head.
REQ-025 Load rejection: cpu_req=1, cpu_wr=0 -> addr_ok=0, no enqueue, empty unchanged.
REQ-026 Reset mid-operation: resetn low in WAIT with count=3 -> count=0, bus_req=0, empty=1 immediately; later bus_data_ok causes no pop.
